// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// video_pkg
// Types and default geometry shared by the video capture and output blocks.
// Rev 1.0
// ============================================================================
package video_pkg;

    localparam int c_VID_WIDTH    = 640;
    localparam int c_VID_HEIGHT   = 480;
    localparam int c_PIX_PER_WORD = 4;
    localparam int c_WORD_W       = 8 * c_PIX_PER_WORD;

    typedef logic [c_WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        DROP   = 2'd3
    } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_packer.sv
`default_nettype none
// ============================================================================
// pixel_packer
// Packs 8-bit pixels into FIFO words and issues the write strobe.
// Rev 1.0
// ============================================================================
module pixel_packer #(
    parameter int PIX_PER_WORD = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clear,
    input  logic                      i_push,
    input  logic [7:0]                i_pix,
    input  logic                      i_line_end,
    input  logic                      i_fifo_full,
    output logic [8*PIX_PER_WORD-1:0] o_w_data,
    output logic                      o_w_en,
    output logic                      o_overflow
);

    localparam int c_LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    logic [c_LANE_W-1:0]       r_lane;
    logic [8*PIX_PER_WORD-1:0] r_lanes;
    logic [8*PIX_PER_WORD-1:0] w_fill;
    logic                      w_last;
    logic                      w_emit;

    // Current word with the incoming pixel merged into its lane; untouched lanes stay zero.
    for (genvar l = 0; l < PIX_PER_WORD; l++) begin : g_lane
        assign w_fill[8*l +: 8] = (i_push && (r_lane == c_LANE_W'(l))) ? i_pix : r_lanes[8*l +: 8];
    end

    assign w_last     = i_push && (r_lane == c_LANE_W'(PIX_PER_WORD - 1));
    assign w_emit     = w_last || (i_line_end && (r_lane != '0));
    assign o_overflow = w_emit && i_fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane   <= '0;
            r_lanes  <= '0;
            o_w_data <= '0;
            o_w_en   <= 1'b0;
        end else begin
            o_w_en <= w_emit && !i_fifo_full;
            if (w_emit && !i_fifo_full) begin
                o_w_data <= w_fill;
            end
            if (i_clear || i_line_end || w_last) begin
                r_lane  <= '0;
                r_lanes <= '0;
            end else if (i_push) begin
                r_lane  <= r_lane + 1'b1;
                r_lanes <= w_fill;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/video_in_capture.sv
`default_nettype none
// ============================================================================
// video_in_capture
// Samples the video stream, checks frame geometry and writes packed pixels to the FIFO.
// Rev 1.0
// ============================================================================
module video_in_capture
    import video_pkg::*;
#(
    parameter int p_WIDTH        = c_VID_WIDTH,
    parameter int p_HEIGHT       = c_VID_HEIGHT,
    parameter int p_PIX_PER_WORD = c_PIX_PER_WORD
) (
    input  logic                        clk,
    input  logic                        RST,
    input  logic [7:0]                  pixel_in,
    input  logic                        frame_valid,
    input  logic                        line_valid,
    input  logic                        fifo_full,
    input  logic                        clr_err,
    output logic [8*p_PIX_PER_WORD-1:0] w_data,
    output logic                        w_en,
    output logic                        frame_start,
    output logic                        frame_done,
    output logic [9:0]                  line_cnt,
    output logic                        err_overflow,
    output logic                        err_geom
);

    localparam logic [10:0] c_COL_MAX  = 11'h7FF;
    localparam logic [9:0]  c_LINE_MAX = 10'h3FF;

    logic [7:0]  r_pix;
    logic        r_fv, r_fv_d, r_lv, r_lv_d;
    logic [10:0] r_col;
    logic        r_fend_pend;
    cap_state_t  r_state, w_state_next;

    logic w_fv_rise, w_fv_fall, w_lv_fall;
    logic w_start, w_push, w_line_end, w_fend, w_stray;
    logic w_ovf, w_geom, w_pk_clear;

    // frame_valid resets high so a frame already in progress at reset release is never seen as a rising edge.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_pix  <= '0;
            r_fv   <= 1'b1;
            r_fv_d <= 1'b1;
            r_lv   <= 1'b0;
            r_lv_d <= 1'b0;
        end else begin
            r_pix  <= pixel_in;
            r_fv   <= frame_valid;
            r_fv_d <= r_fv;
            r_lv   <= line_valid;
            r_lv_d <= r_lv;
        end
    end

    assign w_fv_rise = r_fv && !r_fv_d;
    assign w_fv_fall = !r_fv && r_fv_d;
    assign w_lv_fall = !r_lv && r_lv_d;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SYNC:    if (!r_fv) w_state_next = IDLE;
            IDLE:    if (w_fv_rise) w_state_next = ACTIVE;
            ACTIVE: begin
                // A lost word poisons the frame; if the frame is already closing there is nothing left to drop.
                if (w_ovf) begin
                    w_state_next = w_fv_fall ? IDLE : DROP;
                end else if (w_fv_fall) begin
                    w_state_next = IDLE;
                end
            end
            DROP:    if (w_fv_fall) w_state_next = IDLE;
            default: w_state_next = SYNC;
        endcase
    end

    always_comb begin
        w_start    = 1'b0;
        w_push     = 1'b0;
        w_line_end = 1'b0;
        w_fend     = 1'b0;
        w_stray    = 1'b0;
        case (r_state)
            IDLE: begin
                w_start = w_fv_rise;
                w_push  = w_fv_rise && r_lv;
                w_stray = r_lv && !r_fv;
            end
            ACTIVE: begin
                w_push     = r_lv && r_fv;
                w_line_end = w_lv_fall;
                w_fend     = w_fv_fall && !w_ovf;
                w_stray    = r_lv && !r_fv;
            end
            default: ;
        endcase
    end

    assign w_pk_clear = (r_state != ACTIVE) && !w_push;

    pixel_packer #(
        .PIX_PER_WORD (p_PIX_PER_WORD)
    ) u_packer (
        .clk         (clk),
        .rst         (RST),
        .i_clear     (w_pk_clear),
        .i_push      (w_push),
        .i_pix       (r_pix),
        .i_line_end  (w_line_end),
        .i_fifo_full (fifo_full),
        .o_w_data    (w_data),
        .o_w_en      (w_en),
        .o_overflow  (w_ovf)
    );

    // Frame check runs one cycle after the frame edge so a coincident line end has already bumped line_cnt.
    assign w_geom = w_stray
                 || (w_line_end && (r_col != 11'(p_WIDTH)))
                 || (r_fend_pend && (line_cnt != 10'(p_HEIGHT)));

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_col        <= '0;
            line_cnt     <= '0;
            r_fend_pend  <= 1'b0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            err_overflow <= 1'b0;
            err_geom     <= 1'b0;
        end else begin
            frame_start <= w_start;
            r_fend_pend <= w_fend;
            frame_done  <= r_fend_pend;

            if (w_start) begin
                r_col <= {10'd0, w_push};
            end else if (w_line_end) begin
                r_col <= '0;
            end else if (w_push && (r_col != c_COL_MAX)) begin
                r_col <= r_col + 11'd1;
            end

            if (w_start) begin
                line_cnt <= '0;
            end else if (w_line_end && (line_cnt != c_LINE_MAX)) begin
                line_cnt <= line_cnt + 10'd1;
            end

            err_overflow <= (err_overflow && !clr_err) || w_ovf;
            err_geom     <= (err_geom && !clr_err) || w_geom;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_in_capture.sv
`default_nettype none
// ============================================================================
// tb_video_in_capture
// Scoreboard bench: driver queues expected words, a monitor checks every write strobe.
// Rev 1.0
// ============================================================================
module tb_video_in_capture;
    import video_pkg::*;

    localparam int W = 8;
    localparam int H = 2;

    logic       clk, RST;
    logic [7:0] pixel_in;
    logic       frame_valid, line_valid, fifo_full, clr_err;
    word_t      w_data;
    logic       w_en, frame_start, frame_done, err_overflow, err_geom;
    logic [9:0] line_cnt;

    video_in_capture #(.p_WIDTH(W), .p_HEIGHT(H), .p_PIX_PER_WORD(4)) dut (
        .clk(clk), .RST(RST), .pixel_in(pixel_in), .frame_valid(frame_valid),
        .line_valid(line_valid), .fifo_full(fifo_full), .clr_err(clr_err),
        .w_data(w_data), .w_en(w_en), .frame_start(frame_start), .frame_done(frame_done),
        .line_cnt(line_cnt), .err_overflow(err_overflow), .err_geom(err_geom)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_checks = 0, n_errs = 0;
    word_t exp_data[$];
    int    exp_cyc[$];
    int    got_start = 0, got_done = 0, exp_start = 0, exp_done = 0;
    int    last_wen_cyc = -1, done_cyc = -1;
    int    ff_cnt = 0;
    bit    exp_geom = 0, exp_ovf = 0;
    int    exp_lines = 0;
    int    lens[4];
    bit    pix_rand = 0;
    int    pix_seq = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        word_t d;
        int    c;
        if (!RST) begin
            if (w_en) begin
                if (exp_data.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL unexpected_wen: got w_data %0h with no word expected (cycle %0d)", w_data, cyc);
                end else begin
                    d = exp_data.pop_front();
                    c = exp_cyc.pop_front();
                    chk("w_data", w_data, d);
                    chk("w_en_cycle", cyc, c);
                end
                last_wen_cyc = cyc;
            end
            if (frame_start) got_start++;
            if (frame_done) begin
                got_done++;
                done_cyc = cyc;
                chk("words_before_done", exp_data.size(), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        fifo_full = (ff_cnt > 0);
        if (ff_cnt > 0) ff_cnt--;
    endtask

    function automatic logic [7:0] next_pix();
        if (pix_rand) return 8'($urandom);
        pix_seq++;
        return 8'(pix_seq);
    endfunction

    // Reference: every 4 pixels form a word (first pixel in the low byte); a short tail is
    // flushed zero-padded at line end; both appear 2 cycles after the completing input cycle.
    task automatic run_frame(input int nlines, input bit simul, input int block_word);
        int    wcount, nin;
        bit    dropped;
        word_t word;
        wcount = 0; dropped = 0;
        exp_start++;
        frame_valid = 1'b1;
        tick(); tick();
        for (int l = 0; l < nlines; l++) begin
            word = '0; nin = 0;
            for (int p = 0; p < lens[l]; p++) begin
                line_valid = 1'b1;
                pixel_in = next_pix();
                word[8*nin +: 8] = pixel_in;
                nin++;
                if (nin == 4) begin
                    if (!dropped) begin
                        if (wcount == block_word) begin
                            dropped = 1; ff_cnt = 2; exp_ovf = 1;
                        end else begin
                            exp_data.push_back(word); exp_cyc.push_back(cyc + 2);
                        end
                    end
                    wcount++; word = '0; nin = 0;
                end
                tick();
            end
            line_valid = 1'b0;
            pixel_in = 8'($urandom);
            if (simul && l == nlines - 1) frame_valid = 1'b0;
            if (!dropped) begin
                if (nin != 0) begin
                    exp_data.push_back(word); exp_cyc.push_back(cyc + 2);
                end
                if (lens[l] != W) exp_geom = 1;
            end
            repeat (1 + $urandom_range(0, 2)) tick();
        end
        frame_valid = 1'b0;
        if (dropped) begin
            exp_lines = -1;
        end else begin
            exp_done++;
            exp_lines = nlines;
            if (nlines != H) exp_geom = 1;
        end
        repeat (5) tick();
    endtask

    task automatic check_frame();
        chk("err_geom", err_geom, exp_geom);
        chk("err_overflow", err_overflow, exp_ovf);
        if (exp_lines >= 0) chk("line_cnt", line_cnt, exp_lines);
        chk("frame_start_count", got_start, exp_start);
        chk("frame_done_count", got_done, exp_done);
        clr_err = 1'b1; tick(); clr_err = 1'b0; tick();
        exp_geom = 0; exp_ovf = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; pixel_in = '0; frame_valid = 0; line_valid = 0; fifo_full = 0; clr_err = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w_en", w_en, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_line_cnt", line_cnt, 0);
        chk("rst_errs", {err_geom, err_overflow, frame_start, frame_done}, 0);
        RST = 1'b0;
        repeat (3) tick();

        // Nominal frame, pixels 0x01..0x10
        pix_rand = 0; pix_seq = 0;
        lens = '{8, 8, 0, 0};
        run_frame(2, 0, -1);
        check_frame();

        // Short single line 0xA1..0xA6
        pix_seq = 8'hA0;
        lens = '{6, 0, 0, 0};
        run_frame(1, 0, -1);
        check_frame();

        // Second word refused by a full FIFO, then a clean frame
        pix_rand = 1;
        lens = '{8, 8, 0, 0};
        run_frame(2, 0, 1);
        check_frame();
        run_frame(2, 0, -1);
        check_frame();

        // Reset in the middle of a line while the frame is still valid
        frame_valid = 1'b1; tick(); tick();
        exp_start++;
        line_valid = 1'b1; pixel_in = 8'h55; tick(); pixel_in = 8'h66; tick();
        RST = 1'b1; #1;
        chk("midrst_w_en", w_en, 0);
        chk("midrst_w_data", w_data, 0);
        chk("midrst_line_cnt", line_cnt, 0);
        chk("midrst_flags", {err_geom, err_overflow, frame_start, frame_done}, 0);
        tick(); tick();
        RST = 1'b0;
        repeat (6) tick();
        line_valid = 1'b0; tick(); tick();
        line_valid = 1'b1; repeat (8) tick();
        line_valid = 1'b0; tick(); tick();
        frame_valid = 1'b0; repeat (5) tick();
        chk("after_rst_line_cnt", line_cnt, 0);
        chk("after_rst_done", got_done, exp_done);
        chk("after_rst_start", got_start, exp_start);
        chk("after_rst_geom", err_geom, 0);
        run_frame(2, 0, -1);
        check_frame();

        // Stray line_valid outside a frame, and clr_err priority
        line_valid = 1'b1; tick(); line_valid = 1'b0; repeat (3) tick();
        chk("stray_geom", err_geom, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0; tick();
        chk("lone_clr", err_geom, 0);
        line_valid = 1'b1; tick();
        line_valid = 1'b0; clr_err = 1'b1; tick();
        clr_err = 1'b0; tick(); tick();
        chk("clr_vs_set", err_geom, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0; tick();
        chk("lone_clr2", err_geom, 0);
        chk("stray_starts", got_start, exp_start);

        // Line and frame valid fall together, with and without a partial last word
        lens = '{8, 6, 0, 0};
        run_frame(2, 1, -1);
        chk("done_after_partial", done_cyc, last_wen_cyc + 1);
        check_frame();
        lens = '{8, 8, 0, 0};
        run_frame(2, 1, -1);
        check_frame();

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            for (int l = 0; l < 4; l++)
                lens[l] = ($urandom_range(0, 2) != 0) ? W : int'($urandom_range(3, 10));
            run_frame($urandom_range(1, 3), bit'($urandom_range(0, 1)), -1);
            check_frame();
        end

        repeat (4) tick();
        chk("leftover_words", exp_data.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_in_capture.md
Name: video_in_capture

Overview:
Capture stage directly downstream of the video output generator. It samples the pixel_out, frame_valid and line_valid stream, checks frame geometry, and packs 8-bit pixels into 32-bit words. It writes those words into the frame-buffer FIFO through a write strobe. Overflow and geometry errors are flagged as sticky bits, and frame boundaries are reported as single-cycle pulses.

Parameters:
p_WIDTH, 640, expected active pixels per line
p_HEIGHT, 480, expected active lines per frame
p_PIX_PER_WORD, 4, pixels packed per FIFO word; output word width = 8*p_PIX_PER_WORD

Ports:
clk  in  1  system clock; all logic on posedge
RST  in  1  reset, asynchronous, active-high
pixel_in  in  8  pixel data, valid when line_valid=1
frame_valid  in  1  high for the whole frame, including inter-line gaps
line_valid  in  1  high during active pixels of a line
fifo_full  in  1  downstream FIFO cannot accept a word this cycle
w_data  out  32  packed word; first pixel of the word in bits [7:0]
w_en  out  1  one-cycle write strobe for w_data
frame_start  out  1  one-cycle pulse on accepted frame_valid rising edge
frame_done  out  1  one-cycle pulse when a captured frame closes
line_cnt  out  10  lines completed in the current frame
err_overflow  out  1  sticky: a word was lost because fifo_full was high
err_geom  out  1  sticky: line length or line count mismatch, or line_valid high outside a frame
clr_err  in  1  clears both sticky error bits

Behaviour:
- Reset values: all outputs 0, w_data 0; state SYNC.
- Input pipeline: pixel_in, frame_valid and line_valid are registered once. Edge detection runs on the registered copies.
- FSM states and transitions:
  - SYNC: stays until registered frame_valid=0, so a partial frame is never captured. Then goes to IDLE.
  - IDLE: on the frame_valid rising edge, pulses frame_start, clears line_cnt and the column count, and goes to ACTIVE.
  - ACTIVE: captures pixels (rules below).
  - DROP: discards everything until the frame_valid falling edge, then goes to IDLE. No frame_done is produced from DROP.
- Pixel capture in ACTIVE:
  - Each cycle registered line_valid=1: the pixel goes into byte lane col mod 4, and col increments. col is saturating, 11 bits.
  - The 4th pixel completes the word. The next cycle w_data is loaded and w_en=1, provided fifo_full=0 in that cycle.
  - If fifo_full=1 in that cycle: no w_en, err_overflow is set, and the state goes to DROP.
- Latency: the 4th pixel of a word presented on cycle n produces w_en on cycle n+2.
- Line end (falling edge of registered line_valid):
  - If col mod 4 != 0, the partial word is written with unused lanes zero. The same fifo_full rule applies.
  - If col != p_WIDTH, err_geom is set.
  - line_cnt increments, saturating at 1023, and col clears.
- Frame end (falling edge of registered frame_valid in ACTIVE):
  - If line_cnt != p_HEIGHT, err_geom is set.
  - frame_done pulses and the state goes to IDLE.
  - If line_valid and frame_valid fall in the same cycle, line-end processing happens first. The frame check uses the incremented line_cnt, and frame_done follows one cycle after the final partial-word w_en, if any.
- line_valid=1 while frame_valid=0 (IDLE, ACTIVE between frames): pixels are ignored and err_geom is set.
- Sticky errors: clr_err clears both bits. If a set event and clr_err occur in the same cycle, set wins.
- RST mid-frame: everything returns to SYNC and the remainder of that frame is discarded. No spurious w_en or frame_done.

Decomposition:
- Shared package video_pkg holds:
  - state enum typedef {SYNC, IDLE, ACTIVE, DROP};
  - default constants p_WIDTH/p_HEIGHT, shared with the output generator;
  - a word-type typedef for the 32-bit packed word.
- One natural sub-module, pixel_packer: lane shift register, partial flush, and w_data/w_en registers with the fifo_full check. The FSM and counters stay in the top.

Test Plan:
- Nominal frame with p_WIDTH=8, p_HEIGHT=2, pixels 0x01..0x10 → 4 w_en pulses, first w_data=0x04030201; one frame_start, one frame_done; line_cnt=2; no errors.
- Line of 6 pixels, 0xA1..0xA6, with p_WIDTH=8 → words 0xA4A3A2A1 and 0x0000A6A5; err_geom=1 after line end.
- fifo_full held high on the cycle of the 2nd word → no w_en for that word; err_overflow=1; DROP until frame_valid falls; no frame_done; the next frame is captured normally.
- RST asserted mid-line with frame_valid still high → outputs 0; after release, no capture until frame_valid goes low and then rises again.
- line_valid pulse while frame_valid=0 → err_geom=1 and no w_en. clr_err coinciding with a new geometry error leaves err_geom=1; a lone clr_err clears it.
- line_valid and frame_valid falling in the same cycle with a partial last word → partial w_en, then frame_done on the following cycle; line_cnt equals p_HEIGHT, so no err_geom.
